// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the multi-cycle MIPS datapath control.
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned JIDX_W  = 26;
    localparam int unsigned PCSRC_W = 2;

    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_EXC    = 2'd3
    } pc_src_e;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC source mux with jump-target formation.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic [PCSRC_W-1:0] i_pc_source,
    input  logic [WIDTH-1:0]   i_alu_result,
    input  logic [WIDTH-1:0]   i_alu_out,
    input  logic [WIDTH-29:0]  i_pc_hi,
    input  logic [JIDX_W-1:0]  i_jump_index,
    output logic [WIDTH-1:0]   o_next_pc
);

    logic [WIDTH-1:0] w_jump_target;

    // Jump keeps the current PC region and word-aligns the index.
    assign w_jump_target = {i_pc_hi, i_jump_index, 2'b00};

    always_comb begin
        o_next_pc = i_alu_result;
        case (pc_src_e'(i_pc_source))
            PCSRC_ALU:    o_next_pc = i_alu_result;
            PCSRC_ALUOUT: o_next_pc = i_alu_out;
            PCSRC_JUMP:   o_next_pc = w_jump_target;
            PCSRC_EXC:    o_next_pc = EXC_VECTOR;
            default:      o_next_pc = i_alu_result;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with branch/jump/exception redirect and a
// misaligned-fetch fault FSM capturing EPC and BadAddr.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned      ALIGN_BITS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PCSRC_W-1:0]  PC_Source,
    input  logic [WIDTH-1:0]    ALUResult,
    input  logic [WIDTH-1:0]    ALUOut,
    input  logic [JIDX_W-1:0]   JumpIndex,
    input  logic                PCWrite,
    input  logic                PCWriteCond,
    input  logic                BranchNe,
    input  logic                Zero,
    input  logic                Exception,
    input  logic                ClearErr,
    output logic [WIDTH-1:0]    NextPC,
    output logic [WIDTH-1:0]    PC,
    output logic [WIDTH-1:0]    EPC,
    output logic [WIDTH-1:0]    BadAddr,
    output logic                AddrErr
);

    pc_state_e        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pc, w_pc_nxt;
    logic [WIDTH-1:0] r_epc, w_epc_nxt;
    logic [WIDTH-1:0] r_bad, w_bad_nxt;
    logic [WIDTH-1:0] w_sel_pc;
    logic             w_wr;
    logic             w_mis;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .i_pc_source  (PC_Source),
        .i_alu_result (ALUResult),
        .i_alu_out    (ALUOut),
        .i_pc_hi      (r_pc[WIDTH-1:28]),
        .i_jump_index (JumpIndex),
        .o_next_pc    (w_sel_pc)
    );

    assign w_wr  = PCWrite | (PCWriteCond & (Zero ^ BranchNe));
    assign w_mis = |w_sel_pc[ALIGN_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
            r_bad   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_bad   <= w_bad_nxt;
        end
    end

    // Exception redirect never checks alignment; a fault freezes PC until cleared.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_bad_nxt   = r_bad;
        case (r_state)
            RUN: begin
                if (Exception) begin
                    w_pc_nxt  = EXC_VECTOR;
                    w_epc_nxt = r_pc;
                end else if (w_wr && !w_mis) begin
                    w_pc_nxt = w_sel_pc;
                end else if (w_wr && w_mis) begin
                    w_epc_nxt   = r_pc;
                    w_bad_nxt   = w_sel_pc;
                    w_state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (Exception) begin
                    w_pc_nxt    = EXC_VECTOR;
                    w_state_nxt = RUN;
                end else if (ClearErr) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign NextPC  = w_sel_pc;
    assign PC      = r_pc;
    assign EPC     = r_epc;
    assign BadAddr = r_bad;
    assign AddrErr = (r_state == FAULT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized checks of pc_unit against an arithmetic reference model.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  PC_Source;
    logic [31:0] ALUResult;
    logic [31:0] ALUOut;
    logic [25:0] JumpIndex;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        BranchNe;
    logic        Zero;
    logic        Exception;
    logic        ClearErr;
    logic [31:0] NextPC;
    logic [31:0] PC;
    logic [31:0] EPC;
    logic [31:0] BadAddr;
    logic        AddrErr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [31:0] m_pc, m_epc, m_bad;
    logic        m_err;

    localparam logic [31:0] EXC_V = 32'h8000_0180;

    pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PC_Source   (PC_Source),
        .ALUResult   (ALUResult),
        .ALUOut      (ALUOut),
        .JumpIndex   (JumpIndex),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .BranchNe    (BranchNe),
        .Zero        (Zero),
        .Exception   (Exception),
        .ClearErr    (ClearErr),
        .NextPC      (NextPC),
        .PC          (PC),
        .EPC         (EPC),
        .BadAddr     (BadAddr),
        .AddrErr     (AddrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [1:0] src);
        case (src)
            2'd0:    return ALUResult;
            2'd1:    return ALUOut;
            2'd2:    return (m_pc & 32'hF000_0000) | (32'(JumpIndex) * 32'd4);
            default: return EXC_V;
        endcase
    endfunction

    task automatic apply(input logic rst, input logic [1:0] src, input logic [31:0] alur,
                         input logic [31:0] aluo, input logic [25:0] jidx,
                         input logic pcw, input logic pcwc, input logic bne, input logic z,
                         input logic exc, input logic clr);
        logic [31:0] np;
        bit          wr;
        reset = rst; PC_Source = src; ALUResult = alur; ALUOut = aluo; JumpIndex = jidx;
        PCWrite = pcw; PCWriteCond = pcwc; BranchNe = bne; Zero = z;
        Exception = exc; ClearErr = clr;
        #1;
        np = ref_next(src);
        if (!rst) chk("nextpc", NextPC, np);
        wr = pcw || (pcwc && (z != bne));
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_bad = 32'h0; m_err = 1'b0;
        end else if (!m_err) begin
            if (exc) begin
                m_epc = m_pc; m_pc = EXC_V;
            end else if (wr) begin
                if ((np % 4) != 0) begin
                    m_epc = m_pc; m_bad = np; m_err = 1'b1;
                end else begin
                    m_pc = np;
                end
            end
        end else begin
            if (exc) begin
                m_pc = EXC_V; m_err = 1'b0;
            end else if (clr) begin
                m_err = 1'b0;
            end
        end
        #1;
        chk("pc", PC, m_pc);
        chk("epc", EPC, m_epc);
        chk("badaddr", BadAddr, m_bad);
        chk("addrerr", 32'(AddrErr), 32'(m_err));
    endtask

    task automatic idle();
        apply(1'b0, 2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_pc = '0; m_epc = '0; m_bad = '0; m_err = 1'b0;
        // reset
        apply(1'b1, 2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_pc", PC, 32'h0);
        // sequential increment
        apply(1'b0, 2'd0, 32'h4, 32'h0, 26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("inc_pc", PC, 32'h4);
        // BEQ taken, not taken, BNE taken
        apply(1'b0, 2'd1, 32'h0, 32'h40, 26'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("beq_taken", PC, 32'h40);
        apply(1'b0, 2'd1, 32'h0, 32'h80, 26'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("beq_not_taken", PC, 32'h40);
        apply(1'b0, 2'd1, 32'h0, 32'h80, 26'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bne_taken", PC, 32'h80);
        // jump keeps upper region bits
        apply(1'b0, 2'd0, 32'h3000_0010, 32'h0, 26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 2'd2, 32'h0, 32'h0, 26'h0000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jump_pc", PC, 32'h3000_0400);
        // misaligned fetch, ignored writes, clear
        apply(1'b0, 2'd0, 32'h8, 32'h0, 26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 2'd0, 32'h12, 32'h0, 26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fault_pc", PC, 32'h8);
        chk("fault_bad", BadAddr, 32'h12);
        chk("fault_epc", EPC, 32'h8);
        chk("fault_err", 32'(AddrErr), 32'h1);
        apply(1'b0, 2'd0, 32'h20, 32'h0, 26'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fault_frozen", PC, 32'h8);
        apply(1'b0, 2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_err", 32'(AddrErr), 32'h0);
        // fault then exception keeps fault EPC
        apply(1'b0, 2'd0, 32'h12, 32'h0, 26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fexc_pc", PC, 32'h8000_0180);
        chk("fexc_epc", EPC, 32'h8);
        // exception in RUN overrides a write
        apply(1'b0, 2'd0, 32'h100, 32'h0, 26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rexc_epc", EPC, 32'h8000_0180);
        // reset beats exception in FAULT
        apply(1'b0, 2'd0, 32'h13, 32'h0, 26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_fault_pc", PC, 32'h0);
        chk("rst_fault_bad", BadAddr, 32'h0);
        idle();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            if ($urandom_range(3, 0) != 0) b[1:0] = 2'b00;
            apply(($urandom_range(63, 0) == 0), 2'($urandom_range(3, 0)), a, b, 26'($urandom),
                  1'($urandom_range(2, 0) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(15, 0) == 0), ($urandom_range(3, 0) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
